// File: rtl/alu_uart_if.sv
// alu_uart_if: byte-serial command front end for an ALU (operand A, operand B, opcode -> result byte).
// Define ALU_UART_IF_ZERO_FLAG_EN to follow each result byte with a zero-flag byte.
module alu_uart_if #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] rx_data,
    input  logic            rx_done,
    input  logic            tx_done,
    output logic [BITS-1:0] tx_data,
    output logic            tx_start,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [BITS-1:0] alu_result,
    input  logic            alu_zero,
    output logic            err,
    output logic            drop
);

    localparam logic [2:0] GET_A    = 3'd0;
    localparam logic [2:0] GET_B    = 3'd1;
    localparam logic [2:0] GET_OP   = 3'd2;
    localparam logic [2:0] EXEC     = 3'd3;
    localparam logic [2:0] SEND_RES = 3'd4;
    localparam logic [2:0] WAIT_RES = 3'd5;
`ifdef ALU_UART_IF_ZERO_FLAG_EN
    localparam logic [2:0] SEND_FLG = 3'd6;
    localparam logic [2:0] WAIT_FLG = 3'd7;
`endif

    logic [2:0]      r_state;
    logic [BITS-1:0] r_alu_a;
    logic [BITS-1:0] r_alu_b;
    logic [3:0]      r_alu_op;
    logic [BITS-1:0] r_tx_data;
    logic            r_tx_start;
    logic            r_err;
    logic            r_drop;
`ifdef ALU_UART_IF_ZERO_FLAG_EN
    logic            r_flag;
`else
    logic            w_unused_zero;
    assign w_unused_zero = alu_zero;
`endif

    logic w_op_ok;
    logic w_rx_state;

    assign w_op_ok    = (rx_data[BITS-1:4] == '0);
    assign w_rx_state = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_OP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= GET_A;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= 4'b0000;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            r_drop     <= 1'b0;
`ifdef ALU_UART_IF_ZERO_FLAG_EN
            r_flag     <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            r_drop     <= rx_done && !w_rx_state;
            case (r_state)
                GET_A: if (rx_done) begin
                    r_alu_a <= rx_data;
                    r_state <= GET_B;
                end
                GET_B: if (rx_done) begin
                    r_alu_b <= rx_data;
                    r_state <= GET_OP;
                end
                GET_OP: if (rx_done) begin
                    if (w_op_ok) begin
                        r_alu_op <= rx_data[3:0];
                        r_state  <= EXEC;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= GET_A;
                    end
                end
                // The result byte is launched straight from EXEC; SEND_RES only recovers forward.
                EXEC: begin
                    r_tx_data  <= alu_result;
                    r_tx_start <= 1'b1;
`ifdef ALU_UART_IF_ZERO_FLAG_EN
                    r_flag     <= alu_zero;
`endif
                    r_state    <= WAIT_RES;
                end
                SEND_RES: r_state <= WAIT_RES;
                WAIT_RES: if (tx_done) begin
`ifdef ALU_UART_IF_ZERO_FLAG_EN
                    r_state <= SEND_FLG;
`else
                    r_state <= GET_A;
`endif
                end
`ifdef ALU_UART_IF_ZERO_FLAG_EN
                SEND_FLG: begin
                    r_tx_data  <= {{(BITS-1){1'b0}}, r_flag};
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT_FLG;
                end
                WAIT_FLG: if (tx_done) r_state <= GET_A;
`endif
                default: r_state <= GET_A;
            endcase
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign err      = r_err;
    assign drop     = r_drop;

endmodule

// File: tb/tb_alu_uart_if.sv
// tb_alu_uart_if: directed command bytes against a transaction-level model of the command protocol.
// Honours ALU_UART_IF_ZERO_FLAG_EN when the design is built with the zero-flag reply byte.
module tb_alu_uart_if;

    localparam int BITS = 8;

    logic            clk;
    logic            rst;
    logic [BITS-1:0] rx_data;
    logic            rx_done;
    logic            tx_done;
    logic [BITS-1:0] tx_data;
    logic            tx_start;
    logic [BITS-1:0] alu_a;
    logic [BITS-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [BITS-1:0] alu_result;
    logic            alu_zero;
    logic            err;
    logic            drop;

    alu_uart_if #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
        .tx_data(tx_data), .tx_start(tx_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .err(err), .drop(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? 8'd1 : 8'd0;
            4'b1100: return ~(a | b);
            default: return 8'd0;
        endcase
    endfunction

    // Environment ALU feeding the DUT
    always_comb begin
        alu_result = alu_f(alu_a, alu_b, alu_op);
        alu_zero   = (alu_result == 8'd0);
    end

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic [3:0] m_op = 4'd0;
    int         m_phase = 0;
    logic [7:0] exp_q[$];
    int         exp_err = 0, obs_err = 0;
    int         exp_drop = 0, obs_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: bytes collect into A, B, opcode; a full command queues its reply bytes
    task automatic model_accept(input logic [7:0] b);
        logic [7:0] res;
        case (m_phase)
            0: begin m_a = b; m_phase = 1; end
            1: begin m_b = b; m_phase = 2; end
            2: begin
                if (b[7:4] == 4'd0) begin
                    m_op = b[3:0];
                    res = alu_f(m_a, m_b, m_op);
                    exp_q.push_back(res);
`ifdef ALU_UART_IF_ZERO_FLAG_EN
                    exp_q.push_back((res == 8'd0) ? 8'd1 : 8'd0);
`endif
                    m_phase = 3;
                end else begin
                    exp_err++;
                    m_phase = 0;
                end
            end
            default: exp_drop++;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        model_accept(b);
    endtask

    task automatic wait_tx(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) seen = 1'b1;
        end
        chk({"tx_start_seen_", tag}, {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
    endtask

    task automatic finish_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                              input logic [7:0] exp_res, input logic exp_flg, input bit do_drop);
        chk("no_start_after_one_edge", {31'd0, tx_start}, 32'd0);
        @(posedge clk);
        #1;
        chk("tx_start_two_edges", {31'd0, tx_start}, 32'd1);
        chk("tx_data_result", {24'd0, tx_data}, {24'd0, exp_res});
        chk("alu_a_loaded", {24'd0, alu_a}, {24'd0, a});
        chk("alu_b_loaded", {24'd0, alu_b}, {24'd0, b});
        chk("alu_op_loaded", {28'd0, alu_op}, {28'd0, op});
        wait_tx("res");
        if (do_drop) begin
            send_byte(8'hAA);
            chk("drop_pulse", {31'd0, drop}, 32'd1);
            chk("drop_keeps_a", {24'd0, alu_a}, {24'd0, a});
            chk("drop_keeps_b", {24'd0, alu_b}, {24'd0, b});
        end
        pulse_tx_done();
`ifdef ALU_UART_IF_ZERO_FLAG_EN
        wait_tx("flg");
        chk("tx_data_flag", {24'd0, tx_data}, {31'd0, exp_flg});
        pulse_tx_done();
`else
        chk("single_byte_no_flag", {31'd0, exp_flg | tx_start}, {31'd0, exp_flg});
`endif
        m_phase = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        chk({tag, "_alu_a"}, {24'd0, alu_a}, 32'd0);
        chk({tag, "_alu_b"}, {24'd0, alu_b}, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_drop"}, {31'd0, drop}, 32'd0);
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("model_alu_a", {24'd0, alu_a}, {24'd0, m_a});
            chk("model_alu_b", {24'd0, alu_b}, {24'd0, m_b});
            chk("model_alu_op", {28'd0, alu_op}, {28'd0, m_op});
            if (tx_start === 1'b1) begin
                if (exp_q.size() == 0) chk("tx_start_unexpected", {31'd0, tx_start}, 32'd0);
                else chk("model_tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            if (err === 1'b1) begin
                if (obs_err >= exp_err) chk("err_unexpected", {31'd0, err}, 32'd0);
                else obs_err++;
            end
            if (drop === 1'b1) begin
                if (obs_drop >= exp_drop) chk("drop_unexpected", {31'd0, drop}, 32'd0);
                else obs_drop++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        #2 rst = 1'b1;

        // ADD: 5 + 3
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h02);
        finish_cmd(8'h05, 8'h03, 4'b0010, 8'h08, 1'b0, 1'b0);

        // SUB to zero: flag byte is 1 when compiled in
        send_byte(8'h07);
        send_byte(8'h07);
        send_byte(8'h06);
        finish_cmd(8'h07, 8'h07, 4'b0110, 8'h00, 1'b1, 1'b0);

        // Rejected opcode 0x12
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h12);
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_keeps_op", {28'd0, alu_op}, 32'd6);
        repeat (4) @(negedge clk);
        send_byte(8'h09);
        chk("after_err_loads_a", {24'd0, alu_a}, 32'h09);
        send_byte(8'h04);
        send_byte(8'h01);
        finish_cmd(8'h09, 8'h04, 4'b0001, 8'h0D, 1'b0, 1'b0);

        // Byte arriving while waiting on the transmitter is dropped
        send_byte(8'h0C);
        send_byte(8'h0A);
        send_byte(8'h06);
        finish_cmd(8'h0C, 8'h0A, 4'b0110, 8'h02, 1'b0, 1'b1);

        // Reset after A and B, then a fresh AND command
        send_byte(8'h30);
        send_byte(8'h31);
        @(negedge clk);
        #2 rst = 1'b0;
        m_a = 8'd0;
        m_b = 8'd0;
        m_op = 4'd0;
        m_phase = 0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        #2 rst = 1'b1;
        send_byte(8'h04);
        chk("post_reset_first_is_a", {24'd0, alu_a}, 32'h04);
        send_byte(8'h01);
        send_byte(8'h00);
        finish_cmd(8'h04, 8'h01, 4'b0000, 8'h00, 1'b1, 1'b0);

        // SLT and NOR
        send_byte(8'h03);
        send_byte(8'h05);
        send_byte(8'h07);
        finish_cmd(8'h03, 8'h05, 4'b0111, 8'h01, 1'b0, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h0F);
        send_byte(8'h0C);
        finish_cmd(8'hF0, 8'h0F, 4'b1100, 8'h00, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        chk("reply_queue_drained", exp_q.size(), 32'd0);
        chk("err_count", obs_err, exp_err);
        chk("drop_count", obs_drop, exp_drop);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
